mem_port_arbiter: RTL

//  Shares the core's single memory port between instruction fetch (IF) and the execute-stage LSU.
//  - LSU side connects to the EXE outputs: adr_v/adr/is_store/store_data/access_size, and load_data back.
//  - Fixed priority to LSU, with a starvation guard for IF.
//  - One outstanding transaction at a time; every response is routed back to its requester.
//  - A flush (branch/exception) cancels delivery of an in-flight fetch response.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and the LSU.
// LSU has priority; a starvation counter forces IF through after STARVE_MAX consecutive losses.
module mem_port_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_req_v_i,
    input  logic [XLEN-1:0] if_adr_i,
    output logic            if_gnt_o,
    output logic            if_rsp_v_o,
    output logic [XLEN-1:0] if_rdata_o,
    input  logic            ls_req_v_i,
    input  logic [XLEN-1:0] ls_adr_i,
    input  logic            ls_is_store_i,
    input  logic [XLEN-1:0] ls_wdata_i,
    input  logic [2:0]      ls_size_i,
    output logic            ls_gnt_o,
    output logic            ls_rsp_v_o,
    output logic [XLEN-1:0] ls_rdata_o,
    input  logic            flush_i,
    output logic            mem_req_v_o,
    output logic [XLEN-1:0] mem_adr_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [2:0]      mem_size_o,
    input  logic            mem_ready_i,
    input  logic            mem_rsp_v_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            busy_o,
    output logic            err_q_o
);

    typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;
    typedef enum logic {OwnIf, OwnLs} owner_e;

    localparam logic [2:0]       FetchSize = 3'b010;
    localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_MAX);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              drop_q, drop_d;
    logic              err_q, err_d;
    logic              mem_req_v_q, mem_req_v_d;
    logic [XLEN-1:0]   mem_adr_q, mem_adr_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [2:0]        mem_size_q, mem_size_d;

    logic if_ok, if_wins, ls_wins, gnt_fire, rsp_fire;

    always_comb begin
        if_ok   = if_req_v_i & ~flush_i;
        if_wins = if_ok & (~ls_req_v_i | (starve_cnt_q == StarveMax));
        ls_wins = ls_req_v_i & ~if_wins;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        drop_d       = drop_q;
        mem_req_v_d  = mem_req_v_q;
        mem_adr_d    = mem_adr_q;
        mem_we_d     = mem_we_q;
        mem_wdata_d  = mem_wdata_q;
        mem_size_d   = mem_size_q;
        err_d        = err_q | (mem_rsp_v_i & (state_q != StRsp));

        unique case (state_q)
            StIdle: begin
                drop_d = 1'b0;
                if (if_wins) begin
                    state_d      = StReq;
                    owner_d      = OwnIf;
                    mem_req_v_d  = 1'b1;
                    mem_adr_d    = if_adr_i;
                    mem_we_d     = 1'b0;
                    mem_wdata_d  = '0;
                    mem_size_d   = FetchSize;
                    starve_cnt_d = '0;
                end else if (ls_wins) begin
                    state_d     = StReq;
                    owner_d     = OwnLs;
                    mem_req_v_d = 1'b1;
                    mem_adr_d   = ls_adr_i;
                    mem_we_d    = ls_is_store_i;
                    mem_wdata_d = ls_wdata_i;
                    mem_size_d  = ls_size_i;
                    if (if_req_v_i && (starve_cnt_q < StarveMax)) begin
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end
                end
            end
            StReq: begin
                if (flush_i && (owner_q == OwnIf)) drop_d = 1'b1;
                if (mem_ready_i) begin
                    state_d     = StRsp;
                    mem_req_v_d = 1'b0;
                end
            end
            StRsp: begin
                if (mem_rsp_v_i) begin
                    state_d = StIdle;
                    drop_d  = 1'b0;
                end else if (flush_i && (owner_q == OwnIf)) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            owner_q      <= OwnIf;
            starve_cnt_q <= '0;
            drop_q       <= 1'b0;
            err_q        <= 1'b0;
            mem_req_v_q  <= 1'b0;
            mem_adr_q    <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            mem_size_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            drop_q       <= drop_d;
            err_q        <= err_d;
            mem_req_v_q  <= mem_req_v_d;
            mem_adr_q    <= mem_adr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_size_q   <= mem_size_d;
        end
    end

    // A flush arriving with the response itself must also hide the fetch data.
    always_comb begin
        gnt_fire   = (state_q == StReq) & mem_req_v_q & mem_ready_i;
        rsp_fire   = (state_q == StRsp) & mem_rsp_v_i;
        if_gnt_o   = gnt_fire & (owner_q == OwnIf);
        ls_gnt_o   = gnt_fire & (owner_q == OwnLs);
        if_rsp_v_o = rsp_fire & (owner_q == OwnIf) & ~drop_q & ~flush_i;
        ls_rsp_v_o = rsp_fire & (owner_q == OwnLs);
        if_rdata_o = if_rsp_v_o ? mem_rdata_i : '0;
        ls_rdata_o = (ls_rsp_v_o & ~mem_we_q) ? mem_rdata_i : '0;
        busy_o     = (state_q != StIdle);
    end

    assign mem_req_v_o = mem_req_v_q;
    assign mem_adr_o   = mem_adr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_size_o  = mem_size_q;
    assign err_q_o     = err_q;

endmodule
